// File: rtl/riscv_ex_ctrl.sv
// EX-stage sequencing controller: owns the EX valid bit, the ID/MEM handshakes,
// operand forwarding selects, load-use stalls and post-redirect squashing.
module riscv_ex_ctrl #(
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ID_valid,
  output logic       o_ID_ready,
  input  logic [4:0] i_ID_rs1,
  input  logic [4:0] i_ID_rs2,
  input  logic       i_ID_use_rs1,
  input  logic       i_ID_use_rs2,
  output logic       o_EX_valid,
  output logic       o_EX_load,
  output logic [1:0] o_EX_fwd_sel_a,
  output logic [1:0] o_EX_fwd_sel_b,
  input  logic [1:0] i_EX_src_pc,
  input  logic [4:0] i_MEM_rd,
  input  logic       i_MEM_reg_wr_en,
  input  logic [1:0] i_MEM_src_rd,
  input  logic       i_MEM_valid,
  input  logic [4:0] i_WB_rd,
  input  logic       i_WB_reg_wr_en,
  output logic       o_MEM_valid,
  input  logic       i_MEM_ready,
  output logic       o_redirect
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_LDSTALL, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic             use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;

  logic       ex_valid, flushing, hazard, fire, redirect, id_ready, ex_load;
  logic       mem_is_load;
  logic [4:0] ex_rs    [2];
  logic       ex_use   [2];
  logic [1:0] fwd_sel  [2];
  logic       load_hit [2];

  assign ex_valid    = (state_q == S_HOLD) || (state_q == S_LDSTALL);
  assign flushing    = (state_q == S_FLUSH);
  assign mem_is_load = i_MEM_valid && i_MEM_reg_wr_en && (i_MEM_rd != 5'd0) &&
                       (i_MEM_src_rd == 2'b01);

  assign ex_rs[0]  = rs1_q;
  assign ex_rs[1]  = rs2_q;
  assign ex_use[0] = use_rs1_q;
  assign ex_use[1] = use_rs2_q;

  // Per-operand forwarding; a load in MEM cannot forward, its data arrives via WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic mem_match, wb_match;
    assign mem_match = ex_use[gi] && i_MEM_valid && i_MEM_reg_wr_en &&
                       (i_MEM_rd != 5'd0) && (i_MEM_rd == ex_rs[gi]) &&
                       (i_MEM_src_rd != 2'b01);
    assign wb_match  = ex_use[gi] && i_WB_reg_wr_en &&
                       (i_WB_rd != 5'd0) && (i_WB_rd == ex_rs[gi]);
    assign load_hit[gi] = ex_use[gi] && mem_is_load && (i_MEM_rd == ex_rs[gi]);
    assign fwd_sel[gi]  = mem_match ? 2'b01 : (wb_match ? 2'b10 : 2'b00);
  end

  assign hazard   = ex_valid && (load_hit[0] || load_hit[1]);
  assign fire     = ex_valid && !hazard && i_MEM_ready;
  assign redirect = fire && (i_EX_src_pc != 2'b00);
  assign id_ready = flushing || !ex_valid || fire;
  assign ex_load  = id_ready && i_ID_valid && !flushing && !redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_EMPTY;
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use_rs1_q <= use_rs1_d;
      use_rs2_q <= use_rs2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_rs1_d = use_rs1_q;
    use_rs2_d = use_rs2_q;
    if (ex_load) begin
      rs1_d     = i_ID_rs1;
      rs2_d     = i_ID_rs2;
      use_rs1_d = i_ID_use_rs1;
      use_rs2_d = i_ID_use_rs2;
    end
    case (state_q)
      S_EMPTY: begin
        if (ex_load) state_d = S_HOLD;
      end
      S_HOLD, S_LDSTALL: begin
        if (redirect) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(FLUSH_SLOTS - 1);
        end else if (fire) begin
          state_d = ex_load ? S_HOLD : S_EMPTY;
        end else begin
          state_d = hazard ? S_LDSTALL : S_HOLD;
        end
      end
      S_FLUSH: begin
        // Only accepted wrong-path instructions consume a slot.
        if (i_ID_valid) begin
          if (cnt_q == '0) state_d = S_EMPTY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Everything is forced low while reset is held.
  always_comb begin
    o_ID_ready     = id_ready && !i_rst;
    o_EX_load      = ex_load && !i_rst;
    o_EX_valid     = ex_valid && !i_rst;
    o_MEM_valid    = ex_valid && !hazard && !i_rst;
    o_redirect     = redirect && !i_rst;
    o_EX_fwd_sel_a = i_rst ? 2'b00 : fwd_sel[0];
    o_EX_fwd_sel_b = i_rst ? 2'b00 : fwd_sel[1];
  end

endmodule

// File: tb/tb_riscv_ex_ctrl.sv
// Directed plus randomized bench for riscv_ex_ctrl against a behavioural model
// that tracks "EX occupied" and "wrong-path instructions still to discard".
module tb_riscv_ex_ctrl;
  localparam int FLUSH_SLOTS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use1, id_use2;
  logic [4:0] id_rs1, id_rs2;
  logic [1:0] ex_src_pc;
  logic [4:0] mem_rd, wb_rd;
  logic       mem_wr, mem_valid, wb_wr, mem_ready;
  logic [1:0] mem_src_rd;
  logic       o_id_ready, o_ex_valid, o_ex_load, o_mem_valid, o_redirect;
  logic [1:0] o_fwd_a, o_fwd_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_ex_valid;
  int         m_flush_left;
  logic [4:0] m_rs1, m_rs2;
  bit         m_use1, m_use2;
  // Expected outputs for the current cycle
  logic       e_ready, e_load, e_exv, e_memv, e_redir;
  logic [1:0] e_fa, e_fb;

  always #5 clk = ~clk;

  riscv_ex_ctrl #(.FLUSH_SLOTS(FLUSH_SLOTS), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ID_valid(id_valid), .o_ID_ready(o_id_ready),
    .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2),
    .i_ID_use_rs1(id_use1), .i_ID_use_rs2(id_use2),
    .o_EX_valid(o_ex_valid), .o_EX_load(o_ex_load),
    .o_EX_fwd_sel_a(o_fwd_a), .o_EX_fwd_sel_b(o_fwd_b),
    .i_EX_src_pc(ex_src_pc),
    .i_MEM_rd(mem_rd), .i_MEM_reg_wr_en(mem_wr), .i_MEM_src_rd(mem_src_rd),
    .i_MEM_valid(mem_valid),
    .i_WB_rd(wb_rd), .i_WB_reg_wr_en(wb_wr),
    .o_MEM_valid(o_mem_valid), .i_MEM_ready(mem_ready),
    .o_redirect(o_redirect)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input bit use_rs);
    if (!use_rs || rs == 5'd0) return 2'b00;
    if (mem_valid && mem_wr && mem_rd == rs && mem_src_rd != 2'b01) return 2'b01;
    if (wb_wr && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit hz, fire, flushing;
    hz = m_ex_valid && mem_valid && mem_wr && mem_src_rd == 2'b01 && mem_rd != 5'd0 &&
         ((m_use1 && m_rs1 == mem_rd) || (m_use2 && m_rs2 == mem_rd));
    flushing = (m_flush_left > 0);
    fire     = m_ex_valid && !hz && mem_ready;
    e_exv    = m_ex_valid;
    e_memv   = m_ex_valid && !hz;
    e_ready  = flushing || !m_ex_valid || fire;
    e_redir  = fire && ex_src_pc != 2'b00;
    e_load   = e_ready && id_valid && !flushing && !e_redir;
    e_fa     = ref_fwd(m_rs1, m_use1);
    e_fb     = ref_fwd(m_rs2, m_use2);
    if (rst) begin
      {e_exv, e_memv, e_ready, e_redir, e_load} = '0;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end
  endtask

  // Settle, then compare every output with the model.
  task automatic settle_check();
    #2;
    model_eval();
    chk("id_ready",  {1'b0, o_id_ready},  {1'b0, e_ready});
    chk("ex_load",   {1'b0, o_ex_load},   {1'b0, e_load});
    chk("ex_valid",  {1'b0, o_ex_valid},  {1'b0, e_exv});
    chk("mem_valid", {1'b0, o_mem_valid}, {1'b0, e_memv});
    chk("redirect",  {1'b0, o_redirect},  {1'b0, e_redir});
    chk("fwd_a", o_fwd_a, e_fa);
    chk("fwd_b", o_fwd_b, e_fb);
  endtask

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_ex_valid = 0; m_flush_left = 0;
      m_rs1 = '0; m_rs2 = '0; m_use1 = 0; m_use2 = 0;
    end else begin
      if (e_redir) m_flush_left = FLUSH_SLOTS;
      else if (m_flush_left > 0 && id_valid) m_flush_left--;
      if (e_load) begin
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_use1 = id_use1; m_use2 = id_use2;
      end
      m_ex_valid = e_load ? 1'b1 : ((e_memv && mem_ready) ? 1'b0 : m_ex_valid);
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use1 = u1; id_use2 = u2;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic wr,
                         input logic [1:0] src);
    mem_valid = v; mem_rd = rd; mem_wr = wr; mem_src_rd = src;
  endtask

  initial begin
    rst = 1'b1; ex_src_pc = 2'b00; mem_ready = 1'b0; wb_rd = '0; wb_wr = 1'b0;
    set_id(0, 0, 0, 0, 0); set_mem(0, 0, 0, 2'b00);
    m_ex_valid = 0; m_flush_left = 0; m_rs1 = '0; m_rs2 = '0; m_use1 = 0; m_use2 = 0;

    // Reset
    settle_check(); chk("rst_ready", {1'b0, o_id_ready}, 2'b00);
    tick(); tick();
    rst = 1'b0;
    settle_check(); chk("empty_ready", {1'b0, o_id_ready}, 2'b01);

    // add x3 = x1 + x2 with ALU result for x1 in MEM
    set_id(1, 5'd1, 5'd2, 1, 1);
    settle_check(); chk("add_load", {1'b0, o_ex_load}, 2'b01);
    tick();
    set_id(0, 0, 0, 0, 0); set_mem(1, 5'd1, 1, 2'b00);
    settle_check();
    chk("add_fwd_a", o_fwd_a, 2'b01);
    chk("add_fwd_b", o_fwd_b, 2'b00);
    chk("add_memv", {1'b0, o_mem_valid}, 2'b01);

    // MEM priority over WB on rs2 = x5
    mem_ready = 1'b1; set_id(1, 5'd0, 5'd5, 0, 1); set_mem(0, 0, 0, 2'b00);
    settle_check(); tick();
    mem_ready = 1'b0; set_id(0, 0, 0, 0, 0); set_mem(1, 5'd5, 1, 2'b00);
    wb_rd = 5'd5; wb_wr = 1'b1;
    settle_check(); chk("prio_mem", o_fwd_b, 2'b01);
    mem_rd = 5'd0;
    settle_check(); chk("prio_wb", o_fwd_b, 2'b10);
    wb_wr = 1'b0;

    // Load-use on x7
    mem_ready = 1'b1; set_mem(0, 0, 0, 2'b00); set_id(1, 5'd7, 5'd0, 1, 0);
    settle_check(); tick();
    set_id(1, 5'd0, 5'd0, 0, 0); set_mem(1, 5'd7, 1, 2'b01);
    settle_check();
    chk("lu_memv", {1'b0, o_mem_valid}, 2'b00);
    chk("lu_ready", {1'b0, o_id_ready}, 2'b00);
    tick();
    set_mem(0, 0, 0, 2'b00); wb_rd = 5'd7; wb_wr = 1'b1;
    settle_check();
    chk("lu_wb_fwd", o_fwd_a, 2'b10);
    chk("lu_fire", {1'b0, o_mem_valid & mem_ready}, 2'b01);
    tick();
    wb_wr = 1'b0;

    // Taken branch: two wrong-path handshakes discarded (with an idle cycle between)
    ex_src_pc = 2'b01; set_id(1, 5'd6, 5'd6, 1, 1);
    settle_check();
    chk("br_redirect", {1'b0, o_redirect}, 2'b01);
    chk("br_noload", {1'b0, o_ex_load}, 2'b00);
    tick();
    ex_src_pc = 2'b00;
    settle_check();
    chk("br_pulse_end", {1'b0, o_redirect}, 2'b00);
    chk("flush1_noload", {1'b0, o_ex_load}, 2'b00);
    tick();
    id_valid = 1'b0; settle_check(); tick();
    id_valid = 1'b1;
    settle_check(); chk("flush2_noload", {1'b0, o_ex_load}, 2'b00);
    tick();
    set_id(1, 5'd4, 5'd0, 1, 0);
    settle_check(); chk("flush_third_load", {1'b0, o_ex_load}, 2'b01);
    tick();

    // Back-pressure for 4 cycles, then fire and load together
    mem_ready = 1'b0; set_id(1, 5'd9, 5'd0, 1, 0); set_mem(1, 5'd4, 1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("bp_ready", {1'b0, o_id_ready}, 2'b00);
      chk("bp_fwd_a", o_fwd_a, 2'b01);
      tick();
    end
    mem_ready = 1'b1;
    settle_check(); chk("bp_fire_load", {1'b0, o_ex_load & o_id_ready}, 2'b01);
    tick();
    set_id(0, 0, 0, 0, 0); set_mem(0, 0, 0, 2'b00); mem_ready = 1'b0;
    settle_check(); chk("bp_stay_hold", {1'b0, o_ex_valid}, 2'b01);

    // Reset during FLUSH with counter = 1
    mem_ready = 1'b1; ex_src_pc = 2'b10;
    settle_check(); tick();
    ex_src_pc = 2'b00; rst = 1'b1;
    settle_check(); tick();
    settle_check();
    chk("rst_flush_ready", {1'b0, o_id_ready}, 2'b00);
    chk("rst_flush_exv", {1'b0, o_ex_valid}, 2'b00);
    tick();
    rst = 1'b0; set_id(1, 5'd3, 5'd0, 1, 0);
    settle_check(); chk("post_rst_load", {1'b0, o_ex_load}, 2'b01);
    tick();
    set_id(0, 0, 0, 0, 0);
    settle_check(); chk("post_rst_exv", {1'b0, o_ex_valid}, 2'b01);
    tick();

    // Randomized traffic with small register numbers to provoke matches
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      set_id($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 1), $urandom_range(0, 1));
      set_mem($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
              2'($urandom_range(0, 3)));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_wr      = $urandom_range(0, 1);
      mem_ready  = ($urandom_range(0, 3) != 0);
      ex_src_pc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      settle_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
